// File: rtl/pipe_rca_pkg.sv
// rtl/pipe_rca_pkg.sv - shared defaults and sub-mode encoding for the pipelined adder
`ifndef PIPE_RCA_PKG_SV
`define PIPE_RCA_PKG_SV

package pipe_rca_pkg;

  localparam int   DEF_WIDTH = 32;
  localparam int   DEF_SEG   = 8;

  localparam logic MODE_ADD  = 1'b0;
  localparam logic MODE_SUB  = 1'b1;

endpackage

`endif

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_seg.sv
// rtl/rca_seg.sv - combinational ripple-carry segment adder built from full-adder cells
module rca_seg #(
  parameter int SEG = 8
) (
  output logic [SEG-1:0] sum,
  output logic           co,
  output logic           cm,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci
);

  logic [SEG:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // cm is the carry into the segment MSB, needed for signed overflow on the top segment
  assign co = c[SEG];
  assign cm = c[SEG-1];

endmodule

// File: rtl/pipe_rca.sv
// rtl/pipe_rca.sv - pipelined ripple-carry adder/subtractor, one SEG-bit segment per stage
module pipe_rca
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  // Stage registers: index k holds the beat after segment k has been added
  logic             pv   [STAGES];
  logic             psub [STAGES];
  logic             pc   [STAGES];
  logic             pcm  [STAGES];
  logic [WIDTH-1:0] pa   [STAGES];
  logic [WIDTH-1:0] pb   [STAGES];
  logic [WIDTH-1:0] ps   [STAGES];

  // Stage inputs and segment adder hookup
  logic             xv   [STAGES];
  logic             xsub [STAGES];
  logic             xci  [STAGES];
  logic [WIDTH-1:0] xa   [STAGES];
  logic [WIDTH-1:0] xb   [STAGES];
  logic [WIDTH-1:0] xs   [STAGES];
  logic [SEG-1:0]   sa   [STAGES];
  logic [SEG-1:0]   sb   [STAGES];
  logic [SEG-1:0]   sseg [STAGES];
  logic             sco  [STAGES];
  logic             scm  [STAGES];
  logic [WIDTH-1:0] ns   [STAGES];

  logic en;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = pv[STAGES-1];
  assign sum       = ps[STAGES-1];
  assign cout      = pc[STAGES-1];
  assign ovf       = pc[STAGES-1] ^ pcm[STAGES-1];

  always_comb begin
    xv[0]   = in_valid;
    xsub[0] = sub;
    xa[0]   = a;
    xb[0]   = b;
    xs[0]   = '0;
    xci[0]  = (sub == MODE_SUB) ? 1'b1 : cin;
    for (int k = 1; k < STAGES; k++) begin
      xv[k]   = pv[k-1];
      xsub[k] = psub[k-1];
      xa[k]   = pa[k-1];
      xb[k]   = pb[k-1];
      xs[k]   = ps[k-1];
      xci[k]  = pc[k-1];
    end
    // subtraction inverts b per segment; the +1 enters as stage-0 carry-in
    for (int k = 0; k < STAGES; k++) begin
      sa[k] = xa[k][k*SEG +: SEG];
      sb[k] = xb[k][k*SEG +: SEG] ^ {SEG{xsub[k] == MODE_SUB}};
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_seg #(.SEG(SEG)) u_seg (
      .sum (sseg[k]),
      .co  (sco[k]),
      .cm  (scm[k]),
      .a   (sa[k]),
      .b   (sb[k]),
      .ci  (xci[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ns[k]                 = xs[k];
      ns[k][k*SEG +: SEG]   = sseg[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        pv[k]   <= 1'b0;
        psub[k] <= 1'b0;
        pc[k]   <= 1'b0;
        pcm[k]  <= 1'b0;
        pa[k]   <= '0;
        pb[k]   <= '0;
        ps[k]   <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        pv[k]   <= xv[k];
        psub[k] <= xsub[k];
        pc[k]   <= sco[k];
        pcm[k]  <= scm[k];
        pa[k]   <= xa[k];
        pb[k]   <= xb[k];
        ps[k]   <= ns[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_rca.sv
// tb/tb_pipe_rca.sv - directed and scoreboard checks for pipe_rca at WIDTH=16, SEG=4
module tb_pipe_rca;

  localparam int W  = 16;
  localparam int SG = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int          checks = 0;
  int          errors = 0;
  int          got_cnt;
  logic [17:0] expq[$];

  logic [15:0] va[8] = '{16'h0001, 16'h0005, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h1234, 16'h0010, 16'hABCD};
  logic [15:0] vb[8] = '{16'h0002, 16'h0007, 16'h0001, 16'h0001, 16'h0001, 16'h1111, 16'h0010, 16'h1234};
  logic        vs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        vc[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  pipe_rca #(.WIDTH(W), .SEG(SG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum}
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    logic [15:0] yy;
    logic [16:0] r;
    logic        o;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {16'b0, (s ? 1'b1 : ci)};
    o  = (x[15] == yy[15]) && (r[15] != x[15]);
    return {o, r[16], r[15:0]};
  endfunction

  task automatic step(output bit acc);
    logic [17:0] e;
    @(negedge clk);
    acc = in_valid && in_ready && rst_n;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        check("sum", {16'b0, sum}, {16'b0, e[15:0]});
        check("cout", {31'b0, cout}, {31'b0, e[16]});
        check("ovf", {31'b0, ovf}, {31'b0, e[17]});
      end
      got_cnt++;
    end
    if (acc) expq.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic s,
                        input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    a = x; b = y; cin = ci; sub = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd4);
    check({tag, "_sum"}, {16'b0, sum}, {16'b0, es});
    check({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
    check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          acc;
    int          sent;
    int          vcnt;
    bit          held;
    logic [17:0] hold;

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum", {16'b0, sum}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    vcnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) vcnt++;
    end
    check("rst_discard", vcnt, 32'd0);

    single("add_carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    single("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single("add_cin",   16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    single("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    single("sub_cin",   16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Eight back-to-back beats with a three-cycle consumer stall
    sent = 0; got_cnt = 0; held = 1'b0; hold = '0;
    for (int c = 0; c < 60 && (sent < 8 || expq.size() > 0); c++) begin
      in_valid = (sent < 8);
      if (sent < 8) begin
        a = va[sent]; b = vb[sent]; sub = vs[sent]; cin = vc[sent];
      end
      out_ready = !(c >= 5 && c < 8);
      #1;
      if (out_valid && !out_ready) begin
        check("stall_ready", {31'b0, in_ready}, 32'd0);
        if (held) check("stall_hold", {14'b0, ovf, cout, sum}, {14'b0, hold});
        hold = {ovf, cout, sum};
        held = 1'b1;
      end
      step(acc);
      if (acc) sent++;
    end
    check("stream_count", got_cnt, 32'd8);
    check("stream_left", expq.size(), 32'd0);
    check("stream_stalled", {31'b0, held}, 32'd1);

    // Three beats in flight, then a one-cycle reset
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; sub = vs[i]; cin = vc[i];
      step(acc);
    end
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h4444; b = 16'h4444;
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    expq.delete();
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) vcnt++;
      @(posedge clk);
      #1;
    end
    check("flush_none", vcnt, 32'd0);
    single("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Randomised traffic against the reference model
    sent = 0; got_cnt = 0;
    for (int c = 0; c < 40000 && sent < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 50 && expq.size() > 0; c++) step(acc);
    check("rand_sent", sent, 32'd10000);
    check("rand_count", got_cnt, 32'd10000);
    check("rand_left", expq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
